wb_host_arb2: RTL

Two-master Wishbone arbiter that shares the user-project Wishbone slave path between the Caravel management SoC master (m0) and the internal UART/debug master (m1). Sits inside the wb_host block, in front of the wb_interconnect slave port. Grants are held for the whole bus cycle (`cyc`) and alternate round-robin under contention. An optional watchdog aborts cycles to a hung slave.

---
 rtl/wb_host_arb2.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_host_arb2.sv
// ---------------------------------------------------------------------------
// wb_host_arb2 - two-master Wishbone arbiter for the wb_host block.
//
// The user-project Wishbone slave path is shared by two masters:
//   m0 : Caravel management SoC master
//   m1 : internal UART/debug master
//
// A master keeps the grant for its whole bus cycle (cyc high). When both
// masters request at the same time, the one that did not hold the previous
// grant wins.
//
// Optional feature, enabled by defining WB_ARB_TIMEOUT_EN:
//   A watchdog counts cycles in which a strobe is pending with no ack or err.
//   When it expires the cycle is aborted for one clock. s_cyc_o and s_stb_o
//   drop, the owner receives err, and the sticky tmo_flag_o is set.
//   Without the macro the watchdog is absent, tmo_flag_o is tied low and
//   tmo_clr_i is ignored.
//
// Ports
//   wbm_clk_i, wbm_rst_n    clock, asynchronous active-low reset
//   m0_* / m1_*             master-side Wishbone (cyc/stb/we/adr/dat/sel in,
//                           dat/ack/err out)
//   s_*                     slave-side Wishbone towards wb_interconnect
//   gnt_o                   one-hot grant (bit0 = m0, bit1 = m1)
//   tmo_flag_o, tmo_clr_i   sticky watchdog status and its clear
// ---------------------------------------------------------------------------
module wb_host_arb2 #(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          TMO_W   = 8,
    parameter int unsigned TMO_CYC = 200
) (
    input  logic              wbm_clk_i,
    input  logic              wbm_rst_n,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,

    output logic [1:0]        gnt_o,
    output logic              tmo_flag_o,
    input  logic              tmo_clr_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e     state_q;
    logic       last_gnt_q;   // 0 = m0 held the last grant, 1 = m1
    logic [1:0] gnt_q;        // owner, kept through ABORT so it can resume
    logic       bus_on;       // a master currently drives the slave
    logic       abort;
    logic       tmo_hit;      // watchdog expires at the coming edge

    assign bus_on = (state_q == GNT0) || (state_q == GNT1);
    assign abort  = (state_q == ABORT);
    assign gnt_o  = gnt_q;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    // m0 wins a tie only if m1 owned the bus last time
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                        state_q    <= GNT0;
                        gnt_q      <= 2'b01;
                        last_gnt_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state_q    <= GNT1;
                        gnt_q      <= 2'b10;
                        last_gnt_q <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end else if (tmo_hit) begin
                        state_q <= ABORT;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
                        gnt_q   <= 2'b00;
                    end else if (tmo_hit) begin
                        state_q <= ABORT;
                    end
                end
                ABORT: begin
                    // Abort lasts exactly one cycle, then the owner resumes
                    state_q <= gnt_q[1] ? GNT1 : GNT0;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Slave-side mux: address/data follow the owner; cyc/stb are also
    // masked during ABORT so the hung slave sees the cycle terminate.
    // ------------------------------------------------------------------
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (gnt_q[0]) begin
            s_cyc_o = bus_on & m0_cyc_i;
            s_stb_o = bus_on & m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (gnt_q[1]) begin
            s_cyc_o = bus_on & m1_cyc_i;
            s_stb_o = bus_on & m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
    end

    // ------------------------------------------------------------------
    // Master-side responses: zero-latency passthrough to the owner only.
    // ------------------------------------------------------------------
    assign m0_ack_o = (state_q == GNT0) & s_ack_i;
    assign m1_ack_o = (state_q == GNT1) & s_ack_i;
    assign m0_err_o = ((state_q == GNT0) & s_err_i) | (abort & gnt_q[0]);
    assign m1_err_o = ((state_q == GNT1) & s_err_i) | (abort & gnt_q[1]);
    assign m0_dat_o = gnt_q[0] ? s_dat_i : '0;
    assign m1_dat_o = gnt_q[1] ? s_dat_i : '0;

`ifdef WB_ARB_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    logic             pending;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             flag_q;
    logic             flag_d;

    // A strobe is outstanding on the slave with no response this cycle
    assign pending = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
    // An ack arriving at the threshold cycle clears pending, so it wins
    assign tmo_hit = pending & (cnt_q == TMO_W'(TMO_CYC - 1));

    always_comb begin
        cnt_d = '0;
        if (pending) begin
            cnt_d = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + TMO_W'(1);
        end
        flag_d = flag_q;
        if (tmo_clr_i) begin
            flag_d = 1'b0;
        end
        if (tmo_hit) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge wbm_clk_i or negedge wbm_rst_n) begin
        if (!wbm_rst_n) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign tmo_flag_o = flag_q;
`else
    localparam int          UNUSED_TMO_W   = TMO_W;
    localparam int unsigned UNUSED_TMO_CYC = TMO_CYC;
    logic unused_tmo_clr;

    assign unused_tmo_clr = tmo_clr_i;
    assign tmo_hit        = 1'b0;
    assign tmo_flag_o     = 1'b0;
`endif

endmodule
